// File: rtl/fetch_queue_nwide_pkg.sv
// Shared defaults and encodings for the N-wide fetch queue.
package fetch_queue_nwide_pkg;

    localparam int unsigned FETCH_W_DEF = 2;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned ADDR_W_DEF  = 12;
    localparam int unsigned INSN_W_DEF  = 32;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/fq_storage.sv
// Circular data array: FETCH_W writes at consecutive slots, FETCH_W reads from rd_idx onward.
module fq_storage #(
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 12,
    parameter int INSN_W  = 32
) (
    input  logic                         clock,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_idx,
    input  logic [FETCH_W*INSN_W-1:0]    wr_insn,
    input  logic [FETCH_W*ADDR_W-1:0]    wr_pc,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [FETCH_W*INSN_W-1:0]    rd_insn,
    output logic [FETCH_W*ADDR_W-1:0]    rd_pc
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INSN_W-1:0] insn_q [DEPTH];
    logic [INSN_W-1:0] insn_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  r_idx;

    // Slot indices wrap through the PTR_W-bit addition.
    always_comb begin
        insn_d = insn_q;
        pc_d   = pc_q;
        w_idx  = '0;
        if (wr_en) begin
            for (int i = 0; i < FETCH_W; i++) begin
                w_idx         = wr_idx + PTR_W'(i);
                insn_d[w_idx] = wr_insn[i*INSN_W +: INSN_W];
                pc_d[w_idx]   = wr_pc[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        insn_q <= insn_d;
        pc_q   <= pc_d;
    end

    always_comb begin
        rd_insn = '0;
        rd_pc   = '0;
        r_idx   = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            r_idx                          = rd_idx + PTR_W'(i);
            rd_insn[i*INSN_W +: INSN_W]    = insn_q[r_idx];
            rd_pc[i*ADDR_W +: ADDR_W]      = pc_q[r_idx];
        end
    end

endmodule

// File: rtl/fetch_queue_nwide.sv
// N-wide fetch front end: drives FETCH_W imem lanes, buffers insn+PC, presents oldest FETCH_W to decode.
module fetch_queue_nwide
    import fetch_queue_nwide_pkg::*;
#(
    parameter int FETCH_W = FETCH_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSN_W  = INSN_W_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [FETCH_W*ADDR_W-1:0]      imem_addr,
    output logic [FETCH_W-1:0]             imem_rden,
    input  logic [FETCH_W*INSN_W-1:0]      imem_q,
    input  logic                           redirect_valid,
    input  logic [ADDR_W-1:0]              redirect_pc,
    output logic [FETCH_W*INSN_W-1:0]      out_insn,
    output logic [FETCH_W*ADDR_W-1:0]      out_pc,
    output logic [FETCH_W-1:0]             out_valid,
    input  logic [$clog2(FETCH_W+1)-1:0]   deq_count,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy,
    output logic [ADDR_W-1:0]              fetch_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic              enq;
    logic [OCC_W-1:0]  free_slots;
    logic [OCC_W-1:0]  deq_req;
    logic [OCC_W-1:0]  deq_eff;
    logic [FETCH_W*INSN_W-1:0] rd_insn;
    logic [FETCH_W*ADDR_W-1:0] rd_pc;

    // Fetch admission looks only at registered occupancy; a same-cycle dequeue earns no credit.
    always_comb begin
        free_slots = OCC_W'(DEPTH) - occ_q;
        enq        = !reset && !redirect_valid && (free_slots >= OCC_W'(FETCH_W));
        deq_req    = OCC_W'(deq_count);
        deq_eff    = (deq_req > occ_q) ? occ_q : deq_req;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        if (reset) begin
            fetch_pc_d = '0;
            head_d     = '0;
            tail_d     = '0;
            occ_d      = '0;
        end else if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            occ_d      = '0;
        end else begin
            head_d = head_q + PTR_W'(deq_eff);
            occ_d  = occ_q + (enq ? OCC_W'(FETCH_W) : '0) - deq_eff;
            if (enq) begin
                tail_d     = tail_q + PTR_W'(FETCH_W);
                fetch_pc_d = fetch_pc_q + ADDR_W'(FETCH_W);
            end
        end
    end

    always_ff @(posedge clock) begin
        fetch_pc_q <= fetch_pc_d;
        head_q     <= head_d;
        tail_q     <= tail_d;
        occ_q      <= occ_d;
    end

    always_ff @(posedge clock) begin
        if (!reset && !redirect_valid) begin
            assert (OCC_W'(deq_count) <= occ_q);
        end
    end

    fq_storage #(
        .FETCH_W (FETCH_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INSN_W  (INSN_W)
    ) u_storage (
        .clock   (clock),
        .wr_en   (enq),
        .wr_idx  (tail_q),
        .wr_insn (imem_q),
        .wr_pc   (imem_addr),
        .rd_idx  (head_q),
        .rd_insn (rd_insn),
        .rd_pc   (rd_pc)
    );

    // Invalid lanes are forced to NOP/0 so never-written slots cannot leak unknowns.
    always_comb begin
        imem_addr = '0;
        out_insn  = '0;
        out_pc    = '0;
        out_valid = '0;
        imem_rden = {FETCH_W{enq}};
        for (int i = 0; i < FETCH_W; i++) begin
            imem_addr[i*ADDR_W +: ADDR_W] = fetch_pc_q + ADDR_W'(i);
            out_valid[i] = !reset && (occ_q > OCC_W'(i));
            out_insn[i*INSN_W +: INSN_W] = out_valid[i] ? rd_insn[i*INSN_W +: INSN_W]
                                                        : INSN_W'(NOP_INSN);
            out_pc[i*ADDR_W +: ADDR_W]   = out_valid[i] ? rd_pc[i*ADDR_W +: ADDR_W] : '0;
        end
        occupancy = occ_q;
        fetch_pc  = fetch_pc_q;
    end

endmodule

// File: tb/tb_fetch_queue_nwide.sv
// Directed bench for fetch_queue_nwide at FETCH_W=2, DEPTH=8, ADDR_W=12.
module tb_fetch_queue_nwide;

    logic        clock;
    logic        reset;
    logic [23:0] imem_addr;
    logic [1:0]  imem_rden;
    logic [63:0] imem_q;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [63:0] out_insn;
    logic [23:0] out_pc;
    logic [1:0]  out_valid;
    logic [1:0]  deq_count;
    logic [3:0]  occupancy;
    logic [11:0] fetch_pc;

    int checks = 0;
    int errors = 0;

    fetch_queue_nwide #(
        .FETCH_W (2),
        .DEPTH   (8),
        .ADDR_W  (12),
        .INSN_W  (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rden      (imem_rden),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_insn       (out_insn),
        .out_pc         (out_pc),
        .out_valid      (out_valid),
        .deq_count      (deq_count),
        .occupancy      (occupancy),
        .fetch_pc       (fetch_pc)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory image: word at address a is a fixed function of a.
    function automatic logic [31:0] img(input logic [11:0] a);
        return 32'hC0DE_0000 ^ {20'h0, a};
    endfunction

    always_comb imem_q = {img(imem_addr[23:12]), img(imem_addr[11:0])};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  exp_occ;
        logic [11:0] exp_pc;
        logic [1:0]  want;
        logic [1:0]  d;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_count      = '0;

        // Reset hold
        next_cycle();
        settle();
        check("rst_rden", 32'(imem_rden), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        next_cycle();
        reset = 1'b0;

        // Fill from PC 0 with no dequeue
        for (int c = 0; c < 5; c++) begin
            settle();
            check("fill_occ", 32'(occupancy), 32'(2*c));
            if (c < 4) begin
                check("fill_addr0", 32'(imem_addr[11:0]), 32'(2*c));
                check("fill_addr1", 32'(imem_addr[23:12]), 32'(2*c+1));
                check("fill_rden", 32'(imem_rden), 32'h3);
            end else begin
                check("full_rden", 32'(imem_rden), 32'h0);
                check("full_fpc", 32'(fetch_pc), 32'h8);
            end
            next_cycle();
        end

        // Steady state at deq_count=2 from full
        deq_count = 2'd2;
        for (int k = 0; k < 6; k++) begin
            settle();
            check("ss_occ", 32'(occupancy), (k == 0) ? 32'h8 : 32'h6);
            check("ss_pc0", 32'(out_pc[11:0]), 32'(2*k));
            check("ss_pc1", 32'(out_pc[23:12]), 32'(2*k+1));
            check("ss_insn0", out_insn[31:0], img(12'(2*k)));
            check("ss_insn1", out_insn[63:32], img(12'(2*k+1)));
            check("ss_valid", 32'(out_valid), 32'h3);
            next_cycle();
        end

        // Redirect to 0x100 with 6 entries held
        deq_count      = 2'd0;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h100;
        settle();
        check("rd1_occ", 32'(occupancy), 32'h6);
        check("rd1_rden", 32'(imem_rden), 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        check("rd1_occ0", 32'(occupancy), 32'h0);
        check("rd1_valid0", 32'(out_valid), 32'h0);
        check("rd1_addr0", 32'(imem_addr[11:0]), 32'h100);
        check("rd1_addr1", 32'(imem_addr[23:12]), 32'h101);
        check("rd1_rden1", 32'(imem_rden), 32'h3);
        next_cycle();
        settle();
        check("rd1_pc0", 32'(out_pc[11:0]), 32'h100);
        check("rd1_pc1", 32'(out_pc[23:12]), 32'h101);
        check("rd1_valid", 32'(out_valid), 32'h3);
        check("rd1_insn0", out_insn[31:0], img(12'h100));
        check("rd1_occ2", 32'(occupancy), 32'h2);
        next_cycle();

        // Redirect to 0xFFF: lanes wrap to 0x000
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFF;
        settle();
        check("rd2_rden", 32'(imem_rden), 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        check("rd2_addr0", 32'(imem_addr[11:0]), 32'hFFF);
        check("rd2_addr1", 32'(imem_addr[23:12]), 32'h000);
        check("rd2_fpc", 32'(fetch_pc), 32'hFFF);
        next_cycle();
        settle();
        check("rd2_fpc1", 32'(fetch_pc), 32'h001);
        check("rd2_pc0", 32'(out_pc[11:0]), 32'hFFF);
        check("rd2_pc1", 32'(out_pc[23:12]), 32'h000);
        check("rd2_occ", 32'(occupancy), 32'h2);
        next_cycle();

        // Alternating dequeue 1/2; head wraps past entry 7
        exp_occ = 4'd4;
        exp_pc  = 12'hFFF;
        for (int j = 0; j < 20; j++) begin
            want = (j % 2 == 0) ? 2'd1 : 2'd2;
            d    = (4'(want) > exp_occ) ? exp_occ[1:0] : want;
            deq_count = d;
            settle();
            check("alt_occ", 32'(occupancy), 32'(exp_occ));
            check("alt_rden", 32'(imem_rden), (exp_occ <= 4'd6) ? 32'h3 : 32'h0);
            for (int l = 0; l < 2; l++) begin
                if (l < int'(d)) begin
                    check("alt_pc", 32'(out_pc[l*12 +: 12]), 32'(12'(exp_pc + 12'(l))));
                    check("alt_insn", out_insn[l*32 +: 32], img(12'(exp_pc + 12'(l))));
                end
            end
            exp_occ = exp_occ + ((exp_occ <= 4'd6) ? 4'd2 : 4'd0) - 4'(d);
            exp_pc  = exp_pc + 12'(d);
            next_cycle();
        end
        deq_count = 2'd0;

        // Build occupancy 4, then reset (with a competing redirect) for one cycle
        redirect_valid = 1'b1;
        redirect_pc    = 12'h020;
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        next_cycle();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h055;
        settle();
        check("mr_occ4", 32'(occupancy), 32'h4);
        check("mr_rden", 32'(imem_rden), 32'h0);
        check("mr_valid", 32'(out_valid), 32'h0);
        next_cycle();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        settle();
        check("mr_occ0", 32'(occupancy), 32'h0);
        check("mr_fpc", 32'(fetch_pc), 32'h0);
        check("mr_valid0", 32'(out_valid), 32'h0);
        check("mr_addr0", 32'(imem_addr[11:0]), 32'h0);
        next_cycle();
        settle();
        check("mr_occ2", 32'(occupancy), 32'h2);
        check("mr_pc0", 32'(out_pc[11:0]), 32'h0);
        check("mr_pc1", 32'(out_pc[23:12]), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
